// File: rtl/icache_direct.sv
// Direct-mapped instruction cache with one word per line and a single outstanding refill.
// Hits are delivered one cycle after the request; a miss is delivered one cycle after mem_rdy.
module icache_direct #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INST_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  if2cache_req,
    input  logic [ADDR_WIDTH-1:0] if2cache_pc,
    output logic                  cache2if_valid,
    output logic [INST_WIDTH-1:0] cache2if_inst,
    output logic                  cache_busy,
    output logic                  cache2mem_upd_en,
    output logic [ADDR_WIDTH-1:0] cache2mem_PC,
    input  logic                  mem_rdy,
    input  logic [INST_WIDTH-1:0] mem2cache_inst
);

    localparam int unsigned Lines    = 1 << INDEX_WIDTH;
    localparam int unsigned TagWidth = ADDR_WIDTH - INDEX_WIDTH - 2;

    typedef enum logic {StIdle, StMiss} state_e;

    state_e                  state_q;
    logic                    discard_q;
    logic [Lines-1:0]        valid_q;
    logic [TagWidth-1:0]     tag_q  [Lines];
    logic [INST_WIDTH-1:0]   data_q [Lines];

    logic [INDEX_WIDTH-1:0]  req_index;
    logic [TagWidth-1:0]     req_tag;
    logic [INDEX_WIDTH-1:0]  fill_index;
    logic [TagWidth-1:0]     fill_tag;
    logic                    hit;
    logic                    fill_en;
    logic                    unused_pc_lsb;

    assign req_index     = if2cache_pc[INDEX_WIDTH+1:2];
    assign req_tag       = if2cache_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    // The outstanding miss address doubles as the refill index/tag holder.
    assign fill_index    = cache2mem_PC[INDEX_WIDTH+1:2];
    assign fill_tag      = cache2mem_PC[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign hit           = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign fill_en       = rdy_in && (state_q == StMiss) && mem_rdy;
    assign unused_pc_lsb = ^if2cache_pc[1:0];

    // Dropping upd_en in the completion cycle keeps the controller from re-latching.
    assign cache_busy       = (state_q == StMiss);
    assign cache2mem_upd_en = (state_q == StMiss) && !mem_rdy;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= StIdle;
            discard_q      <= 1'b0;
            valid_q        <= '0;
            cache2if_valid <= 1'b0;
            cache2if_inst  <= '0;
            cache2mem_PC   <= '0;
        end else if (rdy_in) begin
            cache2if_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (if2cache_req && !clear_in) begin
                        if (hit) begin
                            cache2if_valid <= 1'b1;
                            cache2if_inst  <= data_q[req_index];
                        end else begin
                            cache2mem_PC <= {if2cache_pc[ADDR_WIDTH-1:2], 2'b00};
                            state_q      <= StMiss;
                        end
                    end
                end
                StMiss: begin
                    if (mem_rdy) begin
                        valid_q[fill_index] <= 1'b1;
                        state_q             <= StIdle;
                        discard_q           <= 1'b0;
                        if (!clear_in && !discard_q) begin
                            cache2if_valid <= 1'b1;
                            cache2if_inst  <= mem2cache_inst;
                        end
                    end else if (clear_in) begin
                        discard_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= mem2cache_inst;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed table-driven bench for icache_direct: each row gives one cycle's inputs and the
// outputs expected during that cycle, followed by a hand-written asynchronous-reset sequence.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        if2cache_req;
    logic [31:0] if2cache_pc;
    logic        cache2if_valid;
    logic [31:0] cache2if_inst;
    logic        cache_busy;
    logic        cache2mem_upd_en;
    logic [31:0] cache2mem_PC;
    logic        mem_rdy;
    logic [31:0] mem2cache_inst;

    int checks   = 0;
    int failures = 0;

    icache_direct #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .INDEX_WIDTH(4)
    ) dut (
        .clk             (clk),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .clear_in        (clear_in),
        .if2cache_req    (if2cache_req),
        .if2cache_pc     (if2cache_pc),
        .cache2if_valid  (cache2if_valid),
        .cache2if_inst   (cache2if_inst),
        .cache_busy      (cache_busy),
        .cache2mem_upd_en(cache2mem_upd_en),
        .cache2mem_PC    (cache2mem_PC),
        .mem_rdy         (mem_rdy),
        .mem2cache_inst  (mem2cache_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        clr;
        logic        rdy;
        logic        mrdy;
        logic [31:0] minst;
        logic        e_valid;
        logic [31:0] e_inst;
        logic        e_busy;
        logic        e_upd;
        logic [31:0] e_mpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic req, input logic [31:0] pc, input logic clr,
                               input logic rdy, input logic mrdy, input logic [31:0] minst,
                               input logic ev, input logic [31:0] ei, input logic eb,
                               input logic eu, input logic [31:0] em);
        vec_t r;
        r.req = req;   r.pc = pc;     r.clr = clr;   r.rdy = rdy;
        r.mrdy = mrdy; r.minst = minst;
        r.e_valid = ev; r.e_inst = ei; r.e_busy = eb; r.e_upd = eu; r.e_mpc = em;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        if2cache_req   = x.req;
        if2cache_pc    = x.pc;
        clear_in       = x.clr;
        rdy_in         = x.rdy;
        mem_rdy        = x.mrdy;
        mem2cache_inst = x.minst;
    endtask

    task automatic compare(input int idx, input vec_t x);
        chk($sformatf("row%0d valid", idx), {31'd0, cache2if_valid}, {31'd0, x.e_valid});
        if (x.e_valid) chk($sformatf("row%0d inst", idx), cache2if_inst, x.e_inst);
        chk($sformatf("row%0d busy", idx), {31'd0, cache_busy}, {31'd0, x.e_busy});
        chk($sformatf("row%0d upd_en", idx), {31'd0, cache2mem_upd_en}, {31'd0, x.e_upd});
        if (x.e_busy) chk($sformatf("row%0d mem_pc", idx), cache2mem_PC, x.e_mpc);
    endtask

    initial begin
        // Cold miss on 0x10, then hit.
        vecs.push_back(v(1, 'h10, 0, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            0, 0, 1, 1, 'h10));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            0, 0, 1, 1, 'h10));
        vecs.push_back(v(0, 0,    0, 1, 1, 'h00500093,   0, 0, 1, 0, 'h10));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            1, 'h00500093, 0, 0, 0));
        vecs.push_back(v(1, 'h10, 0, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            1, 'h00500093, 0, 0, 0));
        // Conflict on index 4: 0x50 evicts 0x10, which then misses again.
        vecs.push_back(v(1, 'h50, 0, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            0, 0, 1, 1, 'h50));
        vecs.push_back(v(0, 0,    0, 1, 1, 'h00000013,   0, 0, 1, 0, 'h50));
        vecs.push_back(v(1, 'h10, 0, 1, 0, 0,            1, 'h00000013, 0, 0, 0));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            0, 0, 1, 1, 'h10));
        vecs.push_back(v(0, 0,    0, 1, 1, 'h00500093,   0, 0, 1, 0, 'h10));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            1, 'h00500093, 0, 0, 0));
        // Flush during miss: line filled, no delivery, later hit.
        vecs.push_back(v(1, 'h20, 0, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,    1, 1, 0, 0,            0, 0, 1, 1, 'h20));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            0, 0, 1, 1, 'h20));
        vecs.push_back(v(0, 0,    0, 1, 1, 'h12345678,   0, 0, 1, 0, 'h20));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(1, 'h20, 0, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            1, 'h12345678, 0, 0, 0));
        // Flush in idle swallows the same-cycle request.
        vecs.push_back(v(1, 'h20, 1, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            0, 0, 0, 0, 0));
        // Flush coinciding with mem_rdy: fill without delivery.
        vecs.push_back(v(1, 'h30, 0, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            0, 0, 1, 1, 'h30));
        vecs.push_back(v(0, 0,    1, 1, 1, 'h0aaa0aaa,   0, 0, 1, 0, 'h30));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(1, 'h30, 0, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            1, 'h0aaa0aaa, 0, 0, 0));
        // Stray mem_rdy in idle must not write the array.
        vecs.push_back(v(0, 0,    0, 1, 1, 'h11111111,   0, 0, 0, 0, 0));
        vecs.push_back(v(1, 'h30, 0, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            1, 'h0aaa0aaa, 0, 0, 0));
        // Request during miss is ignored.
        vecs.push_back(v(1, 'h40, 0, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(1, 'h44, 0, 1, 0, 0,            0, 0, 1, 1, 'h40));
        vecs.push_back(v(0, 0,    0, 1, 1, 'h00100073,   0, 0, 1, 0, 'h40));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            1, 'h00100073, 0, 0, 0));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            0, 0, 0, 0, 0));
        // Three-cycle stall in miss; clear/req while stalled have no effect.
        vecs.push_back(v(1, 'h14, 0, 1, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            0, 0, 1, 1, 'h14));
        vecs.push_back(v(1, 'h24, 1, 0, 0, 0,            0, 0, 1, 1, 'h14));
        vecs.push_back(v(1, 'h24, 1, 0, 0, 0,            0, 0, 1, 1, 'h14));
        vecs.push_back(v(1, 'h24, 1, 0, 0, 0,            0, 0, 1, 1, 'h14));
        vecs.push_back(v(0, 0,    0, 1, 1, 'h00a00513,   0, 0, 1, 0, 'h14));
        vecs.push_back(v(0, 0,    0, 1, 0, 0,            1, 'h00a00513, 0, 0, 0));

        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; if2cache_req = 1'b0;
        if2cache_pc = '0; mem_rdy = 1'b0; mem2cache_inst = '0;
        #12;
        chk("reset valid",  {31'd0, cache2if_valid},   32'd0);
        chk("reset inst",   cache2if_inst,             32'd0);
        chk("reset mem_pc", cache2mem_PC,              32'd0);
        chk("reset upd_en", {31'd0, cache2mem_upd_en}, 32'd0);
        chk("reset busy",   {31'd0, cache_busy},       32'd0);
        @(negedge clk);
        rst_in = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            compare(i, vecs[i]);
        end

        // Asynchronous reset in the middle of a miss on 0x18.
        @(negedge clk);
        drive(v(1, 'h18, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("premid busy",   {31'd0, cache_busy},       32'd1);
        chk("premid mem_pc", cache2mem_PC,              32'h18);
        #2 rst_in = 1'b0;
        #1;
        chk("async upd_en", {31'd0, cache2mem_upd_en}, 32'd0);
        chk("async busy",   {31'd0, cache_busy},       32'd0);
        chk("async mem_pc", cache2mem_PC,              32'd0);
        @(negedge clk);
        rst_in = 1'b1;
        mem_rdy = 1'b1;
        mem2cache_inst = 32'h0bad0bad;
        #1;
        chk("post-reset mem_rdy upd_en", {31'd0, cache2mem_upd_en}, 32'd0);
        @(negedge clk);
        mem_rdy = 1'b0;
        #1;
        chk("post-reset no delivery", {31'd0, cache2if_valid}, 32'd0);
        chk("post-reset busy",        {31'd0, cache_busy},     32'd0);
        @(negedge clk);
        if2cache_req = 1'b1;
        if2cache_pc  = 32'h10;
        @(negedge clk);
        if2cache_req = 1'b0;
        #1;
        chk("post-reset 0x10 valid",  {31'd0, cache2if_valid},   32'd0);
        chk("post-reset 0x10 busy",   {31'd0, cache_busy},       32'd1);
        chk("post-reset 0x10 upd_en", {31'd0, cache2mem_upd_en}, 32'd1);
        chk("post-reset 0x10 mem_pc", cache2mem_PC,              32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
ICACHE_DIRECT -- requirements
Module: icache_direct

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width.
REQ-002 Parameter INST_WIDTH, default 32, instruction word width.
REQ-003 Parameter INDEX_WIDTH, default 4, line index width (16 lines, one word each).
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port rst_in  input  1  reset, asynchronous, active-low.
REQ-006 Port rdy_in  input  1  global enable; low freezes all state.
REQ-007 Port clear_in  input  1  flush from ROB on mispredict; cancels in-flight delivery.
REQ-008 Port if2cache_req  input  1  ifetch fetch request, one cycle per request.
REQ-009 Port if2cache_pc  input  ADDR_WIDTH  fetch address, word-aligned.
REQ-010 Port cache2if_valid  output  1  one-cycle pulse, instruction valid.
REQ-011 Port cache2if_inst  output  INST_WIDTH  fetched instruction.
REQ-012 Port cache_busy  output  1  high while a miss is outstanding; ifetch does not request while high.
REQ-013 Port cache2mem_upd_en  output  1  refill request to memory controller.
REQ-014 Port cache2mem_PC  output  ADDR_WIDTH  refill address.
REQ-015 Port mem_rdy  input  1  one-cycle pulse from memory controller, refill word valid.
REQ-016 Port mem2cache_inst  input  INST_WIDTH  refill word, valid only while mem_rdy=1.

Function
REQ-017 Address split: index = pc[INDEX_WIDTH+1:2], tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2]; pc[1:0] ignored.
REQ-018 Storage: per line one valid bit, one tag, one INST_WIDTH data word.
REQ-019 States: IDLE, MISS; reset enters IDLE.
REQ-020 IDLE, if2cache_req=1, clear_in=0, line valid and tag match (hit): next cycle cache2if_valid=1 with stored word; stay IDLE.
REQ-021 IDLE, if2cache_req=1, clear_in=0, miss: latch {pc[31:2],2'b00} into cache2mem_PC, go MISS; cache2if_valid stays 0.
REQ-022 cache2mem_upd_en = (state==MISS) && !mem_rdy, so the controller never re-latches a request in the completion cycle.
REQ-023 cache2mem_PC held stable throughout MISS; cache_busy = (state==MISS).
REQ-024 MISS, mem_rdy=1: write mem2cache_inst, tag, valid=1 into indexed line; go IDLE; next cycle cache2if_valid=1, cache2if_inst=mem2cache_inst unless discard set.
REQ-025 Hit delivery latency 1 cycle; miss delivery 1 cycle after mem_rdy.
REQ-026 clear_in=1 in IDLE: any request that cycle ignored; cache2if_valid=0 next cycle.
REQ-027 clear_in=1 in MISS: set discard flag; remain MISS until mem_rdy (controller transfer not abortable); line still filled; no delivery; discard cleared on return to IDLE.
REQ-028 clear_in and mem_rdy same cycle: fill line, no delivery.
REQ-029 mem_rdy while IDLE: ignored, no array write.
REQ-030 if2cache_req while MISS: ignored.
REQ-031 Refill to an occupied index overwrites the line unconditionally (direct-mapped).
REQ-032 rdy_in=0: state, array, discard flag and registered outputs hold; cache2if_valid not re-pulsed after rdy_in returns.

Reset
REQ-033 rst_in low, asynchronously: all valid bits 0, state IDLE, discard 0, cache2if_valid 0, cache2if_inst 0, cache2mem_PC 0, cache2mem_upd_en 0, cache_busy 0.
REQ-034 Reset mid-miss abandons the refill; a subsequent mem_rdy is ignored per REQ-029.

Verification
REQ-035 Cold miss: after reset, req pc=0x0000_0010 -> next cycle upd_en=1, cache2mem_PC=0x10, busy=1; mem_rdy with 0x0050_0093 -> upd_en=0 that cycle, next cycle valid=1, inst=0x0050_0093, busy=0.
REQ-036 Hit: then req pc=0x10 -> next cycle valid=1, inst=0x0050_0093, upd_en never asserted.
REQ-037 Conflict: req 0x50 (index 4, new tag) misses and refills 0x0000_0013; req 0x10 then misses again.
REQ-038 Flush: clear_in during MISS for 0x20 -> no valid pulse after mem_rdy, upd_en drops; later req 0x20 hits.
REQ-039 Stall: rdy_in=0 for 3 cycles in MISS -> upd_en, cache2mem_PC, busy unchanged; completion normal afterwards.
REQ-040 Async reset mid-miss: rst_in low between edges -> upd_en and busy 0 immediately; req 0x10 after release misses.
